// File: rtl/i2c_globals_pkg.sv
// Shared I2C constants and the register-target state encoding.
// Used by the target RTL and by bus-side monitors.
package i2c_globals_pkg;

    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } i2c_target_state_e;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// SCL/SDA synchronizers, one-pclk edge pulses and START/STOP detection.
// Edges appear SYNC_STAGES+1 pclk after the pin transition.
module i2c_bus_cond_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic areset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SDA moving while SCL is high is a bus condition, not data
    assign start    = ~sda & sda_q & scl;
    assign stop     = sda & ~sda_q & scl;

endmodule

// File: rtl/i2c_slave_reg_target.sv
// I2C target with a byte-wide register file: pointer write,
// auto-incrementing data writes and auto-incrementing reads.
module i2c_slave_reg_target
    import i2c_globals_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        pclk,
    input  logic                        areset,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        scl_o,
    output logic                        scl_oen,
    output logic                        sda_o,
    output logic                        sda_oen,
    output logic                        wr_valid,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data,
    output logic                        busy
);

    localparam int         AW   = $clog2(NUM_REGS);
    localparam logic [8:0] NREG = 9'(NUM_REGS);

    i2c_target_state_e state, state_n;

    logic [2:0]            cnt, cnt_n;
    logic [I2C_BYTE_W-2:0] shreg, sh_n;
    logic [I2C_BYTE_W-1:0] txb, txb_n, rx;
    logic [AW-1:0]         ptr, ptr_n, ptr_inc;
    logic                  oen, oen_n;
    logic                  busy_n;
    logic                  wr_en;
    logic [I2C_BYTE_W-1:0] regs [NUM_REGS];

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_cond_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .pclk    (pclk),
        .areset  (areset),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .sda     (sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    assign rx      = {shreg, sda_s};
    assign ptr_inc = ptr + AW'(1);
    assign scl_o   = 1'b0;
    assign scl_oen = 1'b1;
    assign sda_o   = 1'b0;
    assign sda_oen = oen;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            txb   <= '0;
            ptr   <= '0;
            oen   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= sh_n;
            txb   <= txb_n;
            ptr   <= ptr_n;
            oen   <= oen_n;
            busy  <= busy_n;
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_valid <= wr_en;
            if (wr_en) begin
                regs[ptr] <= rx;
                wr_addr   <= ptr;
                wr_data   <= rx;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = shreg;
        txb_n   = txb;
        ptr_n   = ptr;
        oen_n   = oen;
        busy_n  = busy;
        wr_en   = 1'b0;
        if (stop) begin
            state_n = ST_IDLE;
            oen_n   = 1'b1;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ST_ADDR;
            cnt_n   = '0;
            oen_n   = 1'b1;
            busy_n  = 1'b1;
        end else begin
            if (scl_rise && (state inside {ST_ADDR, ST_PTR, ST_WDATA})) begin
                sh_n  = rx[I2C_BYTE_W-2:0];
                cnt_n = cnt + 3'd1;
            end
            unique case (state)
                ST_ADDR: begin
                    if (scl_rise && cnt == 3'd7)
                        state_n = (rx[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK
                                                          : ST_WAIT_STOP;
                end
                ST_PTR: begin
                    if (scl_rise && cnt == 3'd7) begin
                        if ({1'b0, rx} < NREG) begin
                            ptr_n   = rx[AW-1:0];
                            state_n = ST_PTR_ACK;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && cnt == 3'd7) begin
                        wr_en   = 1'b1;
                        ptr_n   = ptr_inc;
                        state_n = ST_WDATA_ACK;
                    end
                end
                // first fall drives the ACK, second fall ends the ACK clock
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (oen) begin
                            oen_n = I2C_ACK;
                        end else begin
                            oen_n = 1'b1;
                            if (state != ST_ADDR_ACK) begin
                                state_n = ST_WDATA;
                            end else if (shreg[0]) begin
                                state_n = ST_RDATA;
                                txb_n   = regs[ptr];
                                oen_n   = regs[ptr][I2C_BYTE_W-1];
                            end else begin
                                state_n = ST_PTR;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) state_n = ST_RDATA_ACK;
                    end else if (scl_fall) begin
                        oen_n = txb[~cnt];
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall) begin
                        oen_n = 1'b1;
                    end else if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_n = ST_WAIT_STOP;
                        end else begin
                            ptr_n   = ptr_inc;
                            txb_n   = regs[ptr_inc];
                            state_n = ST_RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
